// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain side of the async FIFO: write-pointer synchroniser, binary/gray
// read pointer, registered empty flag, fill level and sticky underflow flag.
module fifo_rd_ptr_empty #(
  parameter int pointer_width = 4
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     rinc,
  input  logic [pointer_width-1:0] wptr_gray,
  output logic [pointer_width-2:0] raddr,
  output logic [pointer_width-1:0] rptr_gray,
  output logic                     rempty,
  output logic [pointer_width-1:0] rlevel,
  output logic                     rd_err
);

  function automatic logic [pointer_width-1:0] bin2gray(input logic [pointer_width-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above it.
  function automatic logic [pointer_width-1:0] gray2bin(input logic [pointer_width-1:0] g);
    logic [pointer_width-1:0] b;
    b[pointer_width-1] = g[pointer_width-1];
    for (int i = pointer_width - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [pointer_width-1:0] rq1_wptr_r;
  logic [pointer_width-1:0] rq2_wptr_r;
  logic [pointer_width-1:0] rbin_r;
  logic [pointer_width-1:0] rptr_gray_r;
  logic                     rempty_r;
  logic [pointer_width-1:0] rlevel_r;
  logic                     rd_err_r;

  logic                     rpop_s;
  logic                     under_s;
  logic [pointer_width-1:0] rbin_next_s;
  logic [pointer_width-1:0] rgray_next_s;
  logic [pointer_width-1:0] wbin_s;

  // Two-flop synchroniser for the gray write pointer, nothing between stages.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1_wptr_r <= {pointer_width{1'b0}};
      rq2_wptr_r <= {pointer_width{1'b0}};
    end else begin
      rq1_wptr_r <= wptr_gray;
      rq2_wptr_r <= rq1_wptr_r;
    end
  end

  // Next-pointer arithmetic shared by the counter, empty and level registers.
  always_comb begin
    rpop_s       = 1'b0;
    under_s      = 1'b0;
    rbin_next_s  = rbin_r;
    rgray_next_s = {pointer_width{1'b0}};
    wbin_s       = {pointer_width{1'b0}};
    if (rinc) begin
      rpop_s  = ~rempty_r;
      under_s = rempty_r;
    end else begin
      rpop_s  = 1'b0;
      under_s = 1'b0;
    end
    rbin_next_s  = rbin_r + {{(pointer_width-1){1'b0}}, rpop_s};
    rgray_next_s = bin2gray(rbin_next_s);
    wbin_s       = gray2bin(rq2_wptr_r);
  end

  // Read pointer, empty flag, level and sticky underflow registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_r      <= {pointer_width{1'b0}};
      rptr_gray_r <= {pointer_width{1'b0}};
      rempty_r    <= 1'b1;
      rlevel_r    <= {pointer_width{1'b0}};
      rd_err_r    <= 1'b0;
    end else begin
      rbin_r      <= rbin_next_s;
      rptr_gray_r <= rgray_next_s;
      rempty_r    <= (rgray_next_s == rq2_wptr_r);
      rlevel_r    <= wbin_s - rbin_next_s;
      rd_err_r    <= rd_err_r | under_s;
    end
  end

  assign raddr     = rbin_r[pointer_width-2:0];
  assign rptr_gray = rptr_gray_r;
  assign rempty    = rempty_r;
  assign rlevel    = rlevel_r;
  assign rd_err    = rd_err_r;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty: a count-based model predicts each
// edge's outputs into a queue, and a monitor compares them after every edge.
module tb_fifo_rd_ptr_empty;

  localparam int PW    = 4;
  localparam int DEPTH = 8;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rinc = 1'b0;
  logic [PW-1:0] wptr_gray = '0;
  logic [PW-2:0] raddr;
  logic [PW-1:0] rptr_gray;
  logic          rempty;
  logic [PW-1:0] rlevel;
  logic          rd_err;

  fifo_rd_ptr_empty #(.pointer_width(PW)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr_gray(wptr_gray),
    .raddr(raddr), .rptr_gray(rptr_gray), .rempty(rempty),
    .rlevel(rlevel), .rd_err(rd_err)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [PW-2:0] raddr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic [PW-1:0] level;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: total writes and reads ever made, plus the write totals seen per edge.
  int   wtot, rtot, n_edge;
  int   hist[$];
  bit   m_empty, m_err;

  function automatic logic [PW-1:0] gray_of(input int v);
    int m;
    m = v % (1 << PW);
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    wtot = 0; rtot = 0; n_edge = 0;
    hist.delete();
    m_empty = 1'b1; m_err = 1'b0;
  endtask

  // One clock of stimulus: drive inputs and predict the outputs after the next edge.
  task automatic step(input bit ri, input bit wr);
    int   vis;
    exp_t e;
    @(negedge rclk);
    if (wr && (wtot - rtot) < DEPTH) wtot++;
    rinc      = ri;
    wptr_gray = gray_of(wtot);
    hist.push_back(wtot);
    vis = (n_edge >= 2) ? hist[n_edge-2] : 0;
    if (ri && m_empty) m_err = 1'b1;
    if (ri && !m_empty) rtot++;
    m_empty = ((vis - rtot) == 0);
    e.raddr = (PW-1)'(rtot % DEPTH);
    e.rptr  = gray_of(rtot);
    e.empty = m_empty;
    e.level = PW'(vis - rtot);
    e.err   = m_err;
    exp_q.push_back(e);
    n_edge++;
  endtask

  // Reset asserted between edges must take effect with no clock edge.
  task automatic mid_clock_reset();
    @(negedge rclk);
    #2;
    rrst = 1'b1; rinc = 1'b0; wptr_gray = '0;
    #1;
    check("rst_rempty", rempty, 1);
    check("rst_rlevel", rlevel, 0);
    check("rst_raddr", raddr, 0);
    check("rst_rptr_gray", rptr_gray, 0);
    check("rst_rd_err", rd_err, 0);
    @(negedge rclk);
    model_reset();
    rrst = 1'b0;
  endtask

  // Monitor: after each edge out of reset, compare against the oldest prediction.
  logic [PW-1:0] prev_rptr = '0;
  always @(posedge rclk) begin
    #1;
    if (rrst) begin
      prev_rptr = '0;
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("raddr", raddr, e.raddr);
      check("rptr_gray", rptr_gray, e.rptr);
      check("rempty", rempty, e.empty);
      check("rlevel", rlevel, e.level);
      check("rd_err", rd_err, e.err);
      if (rptr_gray != prev_rptr) check("gray_one_bit_step", $countones(rptr_gray ^ prev_rptr), 1);
      prev_rptr = rptr_gray;
    end
  end

  initial begin
    model_reset();
    #12;
    rrst = 1'b0;

    // Single write then a single read.
    step(0, 1);
    repeat (3) step(0, 0);
    step(1, 0);
    repeat (2) step(0, 0);

    // Fill to depth, drain, then underflow for three cycles.
    repeat (8) step(0, 1);
    repeat (3) step(0, 0);
    repeat (8) step(1, 0);
    repeat (3) step(1, 0);
    repeat (3) step(0, 0);

    // Sticky rd_err must be cleared by a reset between edges.
    mid_clock_reset();

    // Build level 3, then steady coincident write+pop pairs, then wrap traffic.
    repeat (3) step(0, 1);
    repeat (3) step(0, 0);
    repeat (12) step(1, 1);
    repeat (20) begin
      step(0, 1);
      step(1, 0);
    end

    // Random traffic with varying read/write bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i < 130) ? 3 : ((i < 260) ? 1 : 2);
      step(($urandom % 4) < bias, ($urandom % 4) >= bias - 1);
    end

    mid_clock_reset();
    repeat (4) step(0, 0);
    repeat (3) @(posedge rclk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
